ssd_scan_driver: RTL and testbench

//  Parametrised time-multiplexed seven-segment driver for the Nexys4 8-digit display.

---
 rtl/ssd_scan_driver_pkg.sv | 30 +++
 rtl/ssd_scan_driver_if.sv | 23 ++
 rtl/ssd_scan_driver_hex_to_ssd.sv | 9 +
 rtl/ssd_scan_driver.sv | 113 +++++++++++
 tb/tb_ssd_scan_driver.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
// Segment codes are {a,b,c,d,e,f,g}, active-low.
package ssd_scan_driver_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b0000001;
            4'h1: code = 7'b1001111;
            4'h2: code = 7'b0010010;
            4'h3: code = 7'b0000110;
            4'h4: code = 7'b1001100;
            4'h5: code = 7'b0100100;
            4'h6: code = 7'b0100000;
            4'h7: code = 7'b0001111;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0000100;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b1100000;
            4'hC: code = 7'b0110001;
            4'hD: code = 7'b1000010;
            4'hE: code = 7'b0110000;
            default: code = 7'b0111000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Display-facing bundle: digit data and control from game logic, anode/segment pins out.
interface ssd_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    lz_en;
    logic                    load;
    logic [NUM_DIGITS-1:0]   An;
    logic [7:0]              seg;
    logic                    frame_tick;

    modport master (
        output value, dp_mask, dig_en, lz_en, load,
        input  An, seg, frame_tick
    );

    modport slave (
        input  value, dp_mask, dig_en, lz_en, load,
        output An, seg, frame_tick
    );
endinterface

// File: rtl/ssd_scan_driver_hex_to_ssd.sv
// Combinational 4-bit to 7-segment decoder, active-low abcdefg.
module hex_to_ssd
    import ssd_scan_driver_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg7_o
);
    assign seg7_o = hex7(nib_i);
endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering,
// anti-ghost blanking at the start of every dwell and optional leading-zero suppression.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 18,
    parameter int BLANK_CYCLES = 64
) (
    input  logic            ClkPort,
    input  logic            Reset,
    ssd_scan_driver_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] BLANK_LIM = SCAN_DIV'(BLANK_CYCLES);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } frame_buf_t;

    logic [SCAN_DIV-1:0]   prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_buf_t            pend_q, pend_d, shadow_q, shadow_d, in_buf;
    logic                  pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  term, wrap, blank, zero_above;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            nib;
    logic [6:0]            seg7;

    assign in_buf = '{value: bus.value, dp: bus.dp_mask, en: bus.dig_en};
    assign term   = &prescaler_q;
    assign wrap   = term && (idx_q == LAST_IDX);

    // NOTE: every _d is given its default first, so no branch can leave a latch behind.
    always_comb begin
        prescaler_d  = prescaler_q + 1'b1;
        idx_d        = idx_q;
        pend_d       = bus.load ? in_buf : pend_q;
        pend_valid_d = pend_valid_q | bus.load;
        shadow_d     = shadow_q;
        frame_tick_d = wrap;
        if (term) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // A load landing on the wrap edge beats anything still pending.
        if (wrap) begin
            if (bus.load) begin
                shadow_d = in_buf;
            end else if (pend_valid_q) begin
                shadow_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Digit i is a leading zero when it and every digit above it hold 0; digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above & (shadow_q.value[4*i +: 4] == 4'h0);
            lz_blank[i] = bus.lz_en & zero_above;
        end
    end

    assign nib = shadow_q.value[{idx_q, 2'b00} +: 4];

    hex_to_ssd u_hex (
        .nib_i  (nib),
        .seg7_o (seg7)
    );

    always_comb begin
        blank = (prescaler_q < BLANK_LIM) | ~shadow_q.en[idx_q] | lz_blank[idx_q];
        an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d = blank ? SEG_OFF : {seg7, ~shadow_q.dp[idx_q]};
    end

    // NOTE: state registers use non-blocking assignment only; reset is synchronous and wins.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            shadow_q     <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.An         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver at NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2.
// Whole frames are captured and compared against hand-computed per-digit segment codes.
module tb_ssd_scan_driver;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ssd_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    ssd_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .ClkPort (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    // exp_seg packs the expected lit code per digit as {d3,d2,d1,d0}; 8'hFF means dark.
    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [31:0] exp_seg;
    } vec_t;

    vec_t       vecs [7];
    logic [3:0] an_cap  [64];
    logic [7:0] seg_cap [64];
    logic       ft_cap  [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [15:0] v, input logic [3:0] dp,
                              input logic [3:0] en, input logic lz);
        bus.value   = v;
        bus.dp_mask = dp;
        bus.dig_en  = en;
        bus.lz_en   = lz;
    endtask

    task automatic pulse_load();
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        step(1);
        while (bus.frame_tick !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check("frame_tick_wait", 32'(bus.frame_tick), 32'd1);
    endtask

    // Sample k of a frame shows digit k/16 at prescaler k%16.
    task automatic capture_now();
        for (int k = 0; k < 64; k++) begin
            step(1);
            an_cap[k]  = bus.An;
            seg_cap[k] = bus.seg;
            ft_cap[k]  = bus.frame_tick;
        end
    endtask

    task automatic capture();
        wait_tick();
        capture_now();
    endtask

    task automatic verify_frame(input string tag, input logic [31:0] exp);
        int         an_err, seg_err, multi, ft_early;
        logic [7:0] dseg, exp_s;
        logic [3:0] onehot, exp_a;
        logic       off;
        for (int d = 0; d < 4; d++) begin
            an_err  = 0;
            seg_err = 0;
            dseg    = exp[8*d +: 8];
            onehot  = 4'b0001 << d;
            for (int p = 0; p < 16; p++) begin
                off   = (p < 2) || (dseg == 8'hFF);
                exp_a = off ? 4'hF : ~onehot;
                exp_s = off ? 8'hFF : dseg;
                if (an_cap[16*d + p] !== exp_a) an_err++;
                if (seg_cap[16*d + p] !== exp_s) seg_err++;
            end
            check($sformatf("%s d%0d An bad cycles", tag, d), an_err, 0);
            check($sformatf("%s d%0d seg bad cycles", tag, d), seg_err, 0);
        end
        multi    = 0;
        ft_early = 0;
        for (int k = 0; k < 64; k++) begin
            if ($countones(~an_cap[k]) > 1) multi++;
            if (k < 63 && ft_cap[k] !== 1'b0) ft_early++;
        end
        check($sformatf("%s multi-anode cycles", tag), multi, 0);
        check($sformatf("%s early frame_tick", tag), ft_early, 0);
        check($sformatf("%s frame_tick at wrap", tag), 32'(ft_cap[63]), 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, 4'b1111, 1'b0, 32'h9F25_1171};
        vecs[1] = '{16'h0030, 4'b0000, 4'b1111, 1'b1, 32'hFFFF_0D03};
        vecs[2] = '{16'h0000, 4'b0000, 4'b1111, 1'b1, 32'hFFFF_FF03};
        vecs[3] = '{16'h4567, 4'b0100, 4'b1011, 1'b0, 32'h99FF_411F};
        vecs[4] = '{16'h8DE9, 4'b1111, 4'b1111, 1'b0, 32'h0084_6008};
        vecs[5] = '{16'h0B0C, 4'b0000, 4'b1111, 1'b1, 32'hFFC1_0363};
        vecs[6] = '{16'h0005, 4'b0010, 4'b1111, 1'b1, 32'hFFFF_FF49};

        rst      = 1'b1;
        bus.load = 1'b0;
        set_inputs(16'h0, 4'h0, 4'h0, 1'b0);
        step(3);
        check("por An", 32'(bus.An), 32'hF);
        check("por seg", 32'(bus.seg), 32'hFF);
        check("por frame_tick", 32'(bus.frame_tick), 32'd0);
        rst = 1'b0;

        // Load a frame, let it reach the shadow, then reset mid-scan.
        set_inputs(16'h12AF, 4'h0, 4'hF, 1'b0);
        pulse_load();
        step(100);
        rst = 1'b1;
        step(3);
        check("rst An", 32'(bus.An), 32'hF);
        check("rst seg", 32'(bus.seg), 32'hFF);
        check("rst frame_tick", 32'(bus.frame_tick), 32'd0);
        check("rst idx", 32'(dut.idx_q), 32'd0);
        check("rst prescaler", 32'(dut.prescaler_q), 32'd0);
        check("rst pend_valid", 32'(dut.pend_valid_q), 32'd0);
        check("rst shadow", 32'(dut.shadow_q), 32'd0);
        rst = 1'b0;
        capture();
        verify_frame("post_reset", 32'hFFFF_FFFF);

        for (int v = 0; v < 7; v++) begin
            set_inputs(vecs[v].value, vecs[v].dp, vecs[v].en, vecs[v].lz);
            pulse_load();
            capture();
            verify_frame($sformatf("vec%0d", v), vecs[v].exp_seg);
        end

        // Mid-frame loads stay invisible until the wrap; the newest one wins.
        set_inputs(16'h12AF, 4'h0, 4'hF, 1'b0);
        pulse_load();
        wait_tick();
        step(21);
        check("dbuf k20 seg", 32'(bus.seg), 32'h11);
        check("dbuf k20 An", 32'(bus.An), 32'hD);
        bus.value = 16'h1111;
        pulse_load();
        step(20);
        check("dbuf k41 seg", 32'(bus.seg), 32'h25);
        check("dbuf k41 An", 32'(bus.An), 32'hB);
        bus.value = 16'h2222;
        pulse_load();
        step(16);
        check("dbuf k58 seg", 32'(bus.seg), 32'h9F);
        check("dbuf k58 An", 32'(bus.An), 32'h7);
        capture();
        verify_frame("dbuf_new", 32'h2525_2525);

        // Pending 4444 is superseded by a load on the wrap edge itself.
        step(11);
        bus.value = 16'h4444;
        pulse_load();
        step(51);
        bus.value = 16'h3333;
        bus.load  = 1'b1;
        step(1);
        bus.load  = 1'b0;
        check("wrap_load frame_tick", 32'(bus.frame_tick), 32'd1);
        capture_now();
        verify_frame("wrap_load", 32'h0D0D_0D0D);
        check("wrap_load pend_valid", 32'(dut.pend_valid_q), 32'd0);
        capture();
        verify_frame("wrap_load_next", 32'h0D0D_0D0D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
